// File: rtl/axi4_lite_initiator.sv
// axi4_lite_initiator
//   Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) to an
//   AXI4-Lite initiator port. One outstanding transaction at a time; AW and W
//   are handshaken independently so the responder may accept them in any order.
//   A sticky timeout flag reports any single handshake that waits too long.
// Ports:
//   clk, reset          : clock (posedge), synchronous active-high reset
//   mem_*               : native request/response (mem_wstrb==0 means read)
//   mem_axi_aw*/w*/b*   : AXI4-Lite write address, write data, write response
//   mem_axi_ar*/r*      : AXI4-Lite read address, read data
//   timeout             : sticky, set once a wait reaches TIMEOUT_CYCLES
module axi4_lite_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIM = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  logic [2:0]               state_q,   state_d;
  logic [31:0]              addr_q,    addr_d;
  logic [31:0]              wdata_q,   wdata_d;
  logic [3:0]               wstrb_q,   wstrb_d;
  logic                     instr_q,   instr_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q,  wvalid_d;
  logic                     bready_q,  bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q,  rready_d;
  logic                     ready_q,   ready_d;
  logic [31:0]              rdata_q,   rdata_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q,  w_done_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                     tout_q,    tout_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, waiting;

  // Handshakes only use registered valid/ready, so each can only fire in the
  // state that owns that channel.
  assign aw_hs = awvalid_q & mem_axi_awready;
  assign w_hs  = wvalid_q  & mem_axi_wready;
  assign b_hs  = bready_q  & mem_axi_bvalid;
  assign ar_hs = arvalid_q & mem_axi_arready;
  assign r_hs  = rready_q  & mem_axi_rvalid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ready_d   = ready_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    waiting   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          if (mem_wstrb == 4'b0000) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_RD_ADDR: begin
        waiting = 1'b1;
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        waiting = 1'b1;
        if (r_hs) begin
          rdata_d  = mem_axi_rdata;
          rready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_WR_REQ: begin
        waiting = 1'b1;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Include this cycle's handshakes so AW+W together cost one edge.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        waiting = 1'b1;
        if (b_hs) begin
          bready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        ready_d   = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    if (!waiting || aw_hs || w_hs || b_hs || ar_hs || r_hs)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;

    tout_d = tout_q | ((TIMEOUT_CYCLES != 0) && (cnt_d >= TO_LIM));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
    end
  end

  assign mem_ready       = ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = {instr_q, 2'b00};
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = {instr_q, 2'b00};
  assign mem_axi_rready  = rready_q;
  assign timeout         = tout_q;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// tb_axi4_lite_initiator
//   Drives native requests and plays an AXI4-Lite responder with per-channel
//   delays. Expected latency, data, addresses and timeout timing come from a
//   word-level memory model and delay arithmetic kept in this bench.
module tb_axi4_lite_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic        timeout;

  always #5 clk = ~clk;

  axi4_lite_initiator #(.TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .timeout(timeout)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] last_rdata;
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic clear_resp();
    mem_axi_awready = 1'b0;
    mem_axi_wready  = 1'b0;
    mem_axi_bvalid  = 1'b0;
    mem_axi_arready = 1'b0;
    mem_axi_rvalid  = 1'b0;
    mem_axi_rdata   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_valid = 1'b0;
    clear_resp();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_rdata = '0;
  endtask

  // One native transaction against a responder with the given channel delays.
  // exp_to: negedge index (counted from the request) at which timeout should
  // first read 1, or 0 for never. abort: assert reset once bready is seen.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic instr,
                         input int unsigned aw_d, input int unsigned w_d,
                         input int unsigned b_d, input int unsigned ar_d,
                         input int unsigned r_d, input int unsigned exp_to,
                         input bit abort);
    int unsigned lat = 0, mem_lat = 0, pulses = 0, viol = 0, to_lat = 0;
    int unsigned ar_w = 0, aw_w = 0, w_w = 0, r_w = 0, b_w = 0;
    int unsigned nar = 0, naw = 0, nw = 0, nr = 0, nb = 0, exp_lat;
    bit ar_f = 0, aw_f = 0, w_f = 0, r_f = 0, b_f = 0, wr_done = 0, fin = 0;
    bit p_ar = 0, p_aw = 0, p_w = 0, ar_n, aw_n, w_n, r_n, b_n;
    bit is_rd;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0, rd_val = '0, got_rdata = '0;
    logic [31:0] g_araddr = '0, g_awaddr = '0, g_wdata = '0;
    logic [2:0]  p_arprot = '0, p_awprot = '0, g_arprot = '0, g_awprot = '0;
    logic [3:0]  p_wstrb = '0, g_wstrb = '0;
    is_rd = (strb == 4'b0000);

    @(negedge clk);
    if (mem_axi_arvalid || mem_axi_awvalid || mem_axi_wvalid || mem_axi_bready ||
        mem_axi_rready || mem_ready) viol++;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    mem_instr = instr;

    while (!fin && lat < 200) begin
      @(negedge clk);
      lat++;
      // A pending valid must still be up with an unchanged payload.
      if (p_ar && (!mem_axi_arvalid || mem_axi_araddr !== p_araddr || mem_axi_arprot !== p_arprot)) viol++;
      if (p_aw && (!mem_axi_awvalid || mem_axi_awaddr !== p_awaddr || mem_axi_awprot !== p_awprot)) viol++;
      if (p_w  && (!mem_axi_wvalid  || mem_axi_wdata  !== p_wdata  || mem_axi_wstrb  !== p_wstrb)) viol++;
      if (is_rd && (mem_axi_awvalid || mem_axi_wvalid || mem_axi_bready)) viol++;
      if (!is_rd && (mem_axi_arvalid || mem_axi_rready)) viol++;
      if (mem_axi_bready && !(aw_f && w_f)) viol++;
      if (ar_f && !r_f && !mem_axi_rready) viol++;
      if (aw_f && w_f && !b_f && !mem_axi_bready) viol++;
      if ((ar_f && mem_axi_arvalid) || (aw_f && mem_axi_awvalid) || (w_f && mem_axi_wvalid) ||
          (r_f && mem_axi_rready) || (b_f && mem_axi_bready)) viol++;
      if (timeout && to_lat == 0) to_lat = lat;

      if (abort && mem_axi_bready) begin
        reset = 1'b1;
        mem_valid = 1'b0;
        clear_resp();
        @(negedge clk);
        reset = 1'b0;
        chk("abort_bready", {31'd0, mem_axi_bready}, 32'd0);
        chk("abort_valids", {29'd0, mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid}, 32'd0);
        chk("abort_ready", {30'd0, mem_ready, mem_axi_rready}, 32'd0);
        last_rdata = '0;
        fin = 1;
      end else if (mem_ready) begin
        pulses++;
        got_rdata = mem_rdata;
        mem_lat = lat;
        mem_valid = 1'b0;
        clear_resp();
        fin = 1;
      end else begin
        mem_axi_arready = mem_axi_arvalid && (ar_w >= ar_d);
        mem_axi_awready = mem_axi_awvalid && (aw_w >= aw_d);
        mem_axi_wready  = mem_axi_wvalid  && (w_w  >= w_d);
        mem_axi_rvalid  = ar_f && !r_f && (r_w >= r_d);
        mem_axi_rdata   = mem_axi_rvalid ? rd_val : $urandom;
        mem_axi_bvalid  = aw_f && w_f && !b_f && (b_w >= b_d);

        ar_n = mem_axi_arvalid && mem_axi_arready;
        aw_n = mem_axi_awvalid && mem_axi_awready;
        w_n  = mem_axi_wvalid  && mem_axi_wready;
        r_n  = mem_axi_rvalid  && mem_axi_rready;
        b_n  = mem_axi_bvalid  && mem_axi_bready;

        if (mem_axi_arvalid && !ar_n) ar_w++;
        if (mem_axi_awvalid && !aw_n) aw_w++;
        if (mem_axi_wvalid  && !w_n)  w_w++;
        if (ar_f && !r_f && !r_n) r_w++;
        if (aw_f && w_f && !b_f && !b_n) b_w++;

        if (ar_n) begin
          nar++; ar_f = 1;
          g_araddr = mem_axi_araddr; g_arprot = mem_axi_arprot;
          rd_val = resp_rd(mem_axi_araddr);
        end
        if (aw_n) begin nar = nar; naw++; aw_f = 1; g_awaddr = mem_axi_awaddr; g_awprot = mem_axi_awprot; end
        if (w_n)  begin nw++; w_f = 1; g_wdata = mem_axi_wdata; g_wstrb = mem_axi_wstrb; end
        if (r_n)  begin nr++; r_f = 1; end
        if (b_n)  begin nb++; b_f = 1; end
        if (aw_f && w_f && !wr_done) begin
          resp_mem[g_awaddr] = merge(resp_rd(g_awaddr), g_wdata, g_wstrb);
          wr_done = 1;
        end

        p_ar = mem_axi_arvalid && !ar_n; p_araddr = mem_axi_araddr; p_arprot = mem_axi_arprot;
        p_aw = mem_axi_awvalid && !aw_n; p_awaddr = mem_axi_awaddr; p_awprot = mem_axi_awprot;
        p_w  = mem_axi_wvalid  && !w_n;  p_wdata  = mem_axi_wdata;  p_wstrb  = mem_axi_wstrb;
      end
    end

    chk("done", {31'd0, fin}, 32'd1);
    if (!is_rd && aw_f && w_f) ref_mem[addr] = merge(ref_rd(addr), wdata, strb);
    if (!abort) begin
      exp_lat = is_rd ? 3 + ar_d + r_d : 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
      chk("latency", mem_lat, exp_lat);
      chk("pulses", pulses, 1);
      if (is_rd) begin
        chk("araddr", g_araddr, addr);
        chk("arprot", {29'd0, g_arprot}, {29'd0, instr, 2'b00});
        chk("rdata", got_rdata, ref_rd(addr));
        chk("rd_counts", {nar[7:0], nr[7:0], naw[7:0], nb[7:0]}, 32'h0101_0000);
        last_rdata = ref_rd(addr);
      end else begin
        chk("awaddr", g_awaddr, addr);
        chk("awprot", {29'd0, g_awprot}, {29'd0, instr, 2'b00});
        chk("wdata", g_wdata, wdata);
        chk("wstrb", {28'd0, g_wstrb}, {28'd0, strb});
        chk("wr_counts", {naw[7:0], nw[7:0], nb[7:0], nar[7:0]}, 32'h0101_0100);
        chk("rdata_hold", got_rdata, last_rdata);
      end
    end
    chk("viol", viol, 0);
    chk("to_first", to_lat, exp_to);
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    clear_resp();
    last_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {25'd0, mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                     mem_axi_rready, mem_ready, timeout}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;

    // Zero-wait instruction fetch.
    resp_mem[32'h100] = 32'h1234_5678;
    ref_mem[32'h100]  = 32'h1234_5678;
    run_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    // Byte write, W accepted 4 cycles before AW.
    run_txn(32'h1000_0000, 32'h41, 4'b0001, 1'b0, 4, 0, 0, 0, 0, 0, 0);
    run_txn(32'h1000_0000, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    // Read data held off for 7 cycles: below the timeout limit.
    run_txn(32'h0000_2000, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 0, 7, 0, 0);
    // Hung AW/W for 20 cycles: timeout first visible 17 negedges after request.
    run_txn(32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 20, 20, 0, 0, 0, 17, 0);
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    do_reset();
    chk("to_cleared", {31'd0, timeout}, 32'd0);
    // Reset while waiting for B, then a read of the same word.
    run_txn(32'h0000_4000, 32'hA5A5_1234, 4'b1100, 1'b0, 0, 0, 10, 0, 0, 0, 1);
    run_txn(32'h0000_4000, 32'h0, 4'b0000, 1'b1, 0, 0, 0, 1, 0, 0, 0);

    // Randomised back-to-back mix over a small address pool.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = 32'h0000_5000 + {26'd0, 4'($urandom_range(0, 7)), 2'b00};
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      run_txn(a, $urandom, s, 1'($urandom_range(0, 1)),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 6), $urandom_range(0, 6), 0, 0);
    end

    @(negedge clk);
    chk("tail_ready", {31'd0, mem_ready}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
